// File: rtl/disk_ii_head.sv
// Disk II drive mechanics: stepper head position, motor spin-down timer and the
// rotating byte stream that reads/writes one track held in the track-buffer DPRAM.
module disk_ii_head #(
  parameter int TRACK_BYTES  = 6656,
  parameter int BYTE_CE      = 32,
  parameter int MOTOR_OFF_CE = 1000000,
  parameter int MAX_HTRACK   = 69
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_1m,
  input  logic [3:0]  phase,
  input  logic        motor_req,
  input  logic        write_mode,
  input  logic        wp,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  latch_dout,
  input  logic        buf_ready,
  input  logic        buf_busy,
  output logic [5:0]  track,
  output logic        active,
  output logic [12:0] ram_addr,
  input  logic [7:0]  ram_do,
  output logic [7:0]  ram_di,
  output logic        ram_we
);

  localparam int MC_W = $clog2(MOTOR_OFF_CE + 1);
  localparam int BC_W = (BYTE_CE > 1) ? $clog2(BYTE_CE) : 1;
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BYTE_CE - 1);
  localparam logic [12:0]     ADDR_LAST = 13'(TRACK_BYTES - 1);
  localparam logic [6:0]      HT_MAX    = 7'(MAX_HTRACK);

  logic [MC_W-1:0] motor_cnt;
  logic [6:0]      htrack;
  logic [BC_W-1:0] bit_cnt;
  logic            adv;
  logic [7:0]      rd_latch;
  logic            valid;
  logic [7:0]      wr_latch;

  logic            stream_en;
  logic            boundary;
  logic [1:0]      p_up;
  logic [1:0]      p_dn;
  logic            step_up;
  logic            step_dn;

  // Motor keeps spinning for MOTOR_OFF_CE ticks after the request drops.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active    <= 1'b0;
      motor_cnt <= '0;
    end else if (motor_req) begin
      active    <= 1'b1;
      motor_cnt <= MC_W'(MOTOR_OFF_CE);
    end else if (ce_1m && active) begin
      if (motor_cnt <= MC_W'(1)) begin
        motor_cnt <= '0;
        active    <= 1'b0;
      end else begin
        motor_cnt <= motor_cnt - 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    p_up    = htrack[1:0] + 2'd1;
    p_dn    = htrack[1:0] - 2'd1;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (phase[p_up] && !phase[p_dn]) step_up = 1'b1;
    if (phase[p_dn] && !phase[p_up]) step_dn = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      htrack <= '0;
    end else if (ce_1m && active) begin
      if (step_up && htrack != HT_MAX)      htrack <= htrack + 1'b1;
      else if (step_dn && htrack != 7'd0)   htrack <= htrack - 1'b1;
    end
  end

  assign track     = htrack[6:1];
  assign stream_en = active & buf_ready & ~buf_busy;
  assign boundary  = stream_en & ce_1m & (bit_cnt == BC_LAST);

  // Pointer advances the clk after a boundary, so ram_we hits the pre-advance address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      adv      <= 1'b0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_di   <= '0;
      rd_latch <= '0;
      valid    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      adv    <= boundary;
      if (stream_en && ce_1m)
        bit_cnt <= (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
      if (adv)
        ram_addr <= (ram_addr == ADDR_LAST) ? '0 : ram_addr + 1'b1;
      if (boundary && write_mode && !wp) begin
        ram_we <= 1'b1;
        ram_di <= wr_latch;
      end
      if (!stream_en) begin
        rd_latch <= '0;
        valid    <= 1'b0;
      end else if (boundary && !write_mode) begin
        rd_latch <= ram_do;
        valid    <= ram_do[7];
      end else if (cpu_rd && valid) begin
        valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    wr_latch <= '0;
    else if (cpu_wr) wr_latch <= cpu_din;
  end

  assign latch_dout = valid ? rd_latch : {1'b0, rd_latch[6:0]};

endmodule

// File: tb/tb_disk_ii_head.sv
// Self-checking bench for disk_ii_head: behavioural DPRAM, bench-side rotation/motor
// model pushing expected reads and writes to scoreboard queues popped by a monitor.
module tb_disk_ii_head;

  localparam int TRACK_BYTES  = 6656;
  localparam int BYTE_CE      = 3;
  localparam int MOTOR_OFF_CE = 10;
  localparam int MAX_HTRACK   = 69;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_1m = 1'b0;
  logic [3:0]  phase = '0;
  logic        motor_req = 1'b0;
  logic        write_mode = 1'b0;
  logic        wp = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  latch_dout;
  logic        buf_ready = 1'b0;
  logic        buf_busy = 1'b0;
  logic [5:0]  track;
  logic        active;
  logic [12:0] ram_addr;
  logic [7:0]  ram_do = '0;
  logic [7:0]  ram_di;
  logic        ram_we;

  logic [7:0]  mem [TRACK_BYTES];
  logic        mem_init = 1'b0;
  logic        poke_en = 1'b0;
  logic [12:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  ent_t        rq[$];
  ent_t        wq[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          bc_m = 0;
  int          ptr_m = 0;
  int          mcnt_m = 0;
  bit          act_m = 1'b0;
  logic [7:0]  wl_m = '0;
  logic [12:0] prev_addr = '0;
  int          h_m;

  disk_ii_head #(
    .TRACK_BYTES (TRACK_BYTES),
    .BYTE_CE     (BYTE_CE),
    .MOTOR_OFF_CE(MOTOR_OFF_CE),
    .MAX_HTRACK  (MAX_HTRACK)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_1m     (ce_1m),
    .phase     (phase),
    .motor_req (motor_req),
    .write_mode(write_mode),
    .wp        (wp),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_din   (cpu_din),
    .latch_dout(latch_dout),
    .buf_ready (buf_ready),
    .buf_busy  (buf_busy),
    .track     (track),
    .active    (active),
    .ram_addr  (ram_addr),
    .ram_do    (ram_do),
    .ram_di    (ram_di),
    .ram_we    (ram_we)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    if (i == 0)      return 8'hD5;
    else if (i == 1) return 8'hAA;
    else             return 8'(i * 29 + 17);
  endfunction

  // Track DPRAM with registered read port.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < TRACK_BYTES; i++) mem[i] <= pat(i);
    end else begin
      if (poke_en) mem[poke_addr] <= poke_data;
      if (ram_we)  mem[ram_addr]  <= ram_di;
    end
    ram_do <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard consumer: writes on each ram_we, reads when the pointer moves on.
  always @(negedge clk) begin
    ent_t e;
    if (reset_n) begin
      if (ram_we) begin
        if (wq.size() == 0) check("wr_unexpected", 32'(ram_we), 32'd0);
        else begin
          e = wq.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(e.addr));
          check("wr_data", 32'(ram_di), 32'(e.data));
        end
      end
      if (ram_addr != prev_addr && rq.size() > 0) begin
        e = rq.pop_front();
        check("rd_addr", 32'(prev_addr), 32'(e.addr));
        check("rd_data", 32'(latch_dout), 32'(e.data));
      end
      prev_addr = ram_addr;
    end
  end

  // Each ce_1m pulse spans two clks; tasks start and end at posedge+1.
  task automatic tick_ce(input int n);
    bit en;
    bit drop;
    for (int i = 0; i < n; i++) begin
      en   = act_m && buf_ready && !buf_busy;
      drop = !motor_req && act_m && (mcnt_m == 1);
      if (en && bc_m == BYTE_CE - 1) begin
        if (write_mode) begin
          if (!wp) wq.push_back('{addr: 13'(ptr_m), data: wl_m});
        end else if (!drop) begin
          rq.push_back('{addr: 13'(ptr_m), data: mem[ptr_m]});
        end
      end
      ce_1m = 1'b1;
      @(posedge clk); #1;
      ce_1m = 1'b0;
      @(posedge clk); #1;
      if (en) begin
        if (bc_m == BYTE_CE - 1) begin
          bc_m  = 0;
          ptr_m = (ptr_m + 1) % TRACK_BYTES;
        end else begin
          bc_m++;
        end
      end
      if (!motor_req && act_m) begin
        mcnt_m--;
        if (mcnt_m == 0) act_m = 1'b0;
      end
    end
  endtask

  task automatic cpu_write(input logic [7:0] v);
    cpu_wr = 1'b1; cpu_din = v;
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    wl_m = v;
  endtask

  task automatic motor_pulse();
    motor_req = 1'b1;
    @(posedge clk); #1;
    act_m = 1'b1; mcnt_m = MOTOR_OFF_CE;
  endtask

  task automatic step(input int idx, input int exp_track);
    phase = 4'(1 << idx);
    tick_ce(1);
    check("track_step", 32'(track), 32'(exp_track));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int up_seq[5]    = '{1, 2, 3, 0, 1};
    int up_trk[5]    = '{0, 1, 1, 2, 2};
    int dn_seq[5]    = '{0, 3, 2, 1, 0};
    int dn_trk[5]    = '{2, 1, 1, 0, 0};

    mem_init = 1'b1;
    @(posedge clk); #1;
    mem_init = 1'b0;
    check("rst_latch", 32'(latch_dout), 32'h00);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_track", 32'(track), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_di", 32'(ram_di), 32'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Full revolution plus two bytes: every byte checked, pointer wraps 6655 -> 0.
    buf_ready = 1'b1;
    motor_pulse();
    check("motor_on", 32'(active), 32'd1);
    tick_ce((TRACK_BYTES + 2) * BYTE_CE);
    check("wrap_addr", 32'(ram_addr), 32'd2);
    check("wrap_model", 32'(ram_addr), 32'(ptr_m));

    // cpu_rd clears valid, hiding bit 7.
    poke_en = 1'b1; poke_addr = 13'd2; poke_data = 8'h96;
    @(posedge clk); #1;
    poke_en = 1'b0;
    tick_ce(BYTE_CE);
    check("latch_96", 32'(latch_dout), 32'h96);
    cpu_rd = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    check("latch_cleared", 32'(latch_dout), 32'h16);

    // buf_busy mid-byte freezes pointer and clears the latch.
    tick_ce(1);
    buf_busy = 1'b1;
    tick_ce(5);
    check("busy_addr", 32'(ram_addr), 32'd3);
    check("busy_latch", 32'(latch_dout), 32'h00);
    buf_busy = 1'b0;
    tick_ce(BYTE_CE - 1);
    check("resume_addr", 32'(ram_addr), 32'd4);

    // Stepper: outward 0->5, back to 0, then saturate at both ends.
    for (int i = 0; i < 5; i++) step(up_seq[i], up_trk[i]);
    for (int i = 0; i < 5; i++) step(dn_seq[i], dn_trk[i]);
    phase = 4'b1000;
    tick_ce(3);
    check("track_floor", 32'(track), 32'd0);
    h_m = 0;
    for (int k = 0; k < 80; k++) begin
      phase = 4'(1 << ((h_m + 1) % 4));
      tick_ce(1);
      if (h_m < MAX_HTRACK) h_m++;
    end
    check("track_ceiling", 32'(track), 32'd34);
    step((MAX_HTRACK + 3) % 4, 34);
    step((MAX_HTRACK + 2) % 4, 33);
    phase = 4'b0000;

    // Write mode: repeated latch bytes, new byte, then write-protected.
    write_mode = 1'b1;
    cpu_write(8'hFF);
    tick_ce(3 * BYTE_CE);
    cpu_write(8'h3C);
    tick_ce(2 * BYTE_CE);
    wp = 1'b1;
    tick_ce(3 * BYTE_CE);
    wp = 1'b0;
    write_mode = 1'b0;
    check("wq_empty", 32'(wq.size()), 32'd0);
    check("write_addr", 32'(ram_addr), 32'(ptr_m));

    // Motor spin-down, then a reassert mid-countdown restarts the timer.
    motor_req = 1'b0;
    tick_ce(MOTOR_OFF_CE - 1);
    check("spin_9", 32'(active), 32'd1);
    tick_ce(1);
    check("spin_10", 32'(active), 32'd0);
    check("off_latch", 32'(latch_dout), 32'h00);
    tick_ce(4);
    check("off_addr", 32'(ram_addr), 32'(ptr_m));
    motor_pulse();
    check("motor_back", 32'(active), 32'd1);
    motor_req = 1'b0;
    tick_ce(5);
    motor_pulse();
    motor_req = 1'b0;
    tick_ce(MOTOR_OFF_CE - 1);
    check("reassert_9", 32'(active), 32'd1);
    tick_ce(1);
    check("reassert_10", 32'(active), 32'd0);

    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
